seq_det_player: RTL
===================

Name: seq_det_player

Overview:
- Test-sequence controller for the one-hot sequence detector FSM (input w; Moore output z asserts after four equal consecutive w values).
- Latches a bit pattern and a length from the switches, clears the detector, then feeds the pattern LSB-first to w, one bit per detector enable.
- Runs either free-running (one bit per clock) or single-step (one bit per push of step).
- Counts z assertions and reports busy/done status to the LEDs.
- The detector's next revision adds an `en` port: it updates state only in cycles where `en` = 1.

Parameters:
- PAT_W, 16, maximum pattern length in bits.
- LEN_W, 5, width of the length input; must hold PAT_W.
- CNT_W, 5, width of the hit counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a run.
- step_mode  input  1  1 = advance only on step; 0 = free-run. Sampled at start.
- step  input  1  advance request in step mode.
- pattern  input  PAT_W  bit sequence; bit 0 is played first.
- len  input  LEN_W  number of bits to play.
- fsm_z  input  1  detector z output.
- fsm_w  output  1  detector w input (registered).
- fsm_en  output  1  detector state-update enable (registered).
- fsm_rst  output  1  detector synchronous reset (registered).
- busy  output  1  run in progress.
- done  output  1  run finished; held until the next start or reset.
- hit_count  output  CNT_W  number of z assertions in the current/last run (saturating).
- bit_idx  output  LEN_W  index of the next bit to play.

Behaviour:
- Reset values: fsm_w=0, fsm_en=0, fsm_rst=1, busy=0, done=0, hit_count=0, bit_idx=0, state=IDLE.
  - fsm_rst=1 holds the detector cleared.
- States: IDLE, CLEAR, PLAY, SETTLE, DONE.
- IDLE / DONE:
  - fsm_en=0.
  - On start: latch pattern, len (clamped to PAT_W if larger) and step_mode; clear hit_count and bit_idx; set done=0; go to CLEAR.
  - Other inputs are ignored.
- CLEAR: exactly one cycle.
  - fsm_rst=1, busy=1.
  - Next state is DONE if latched len=0 (hit_count=0), else PLAY.
- PLAY:
  - fsm_rst=0.
  - An advance event is every cycle (free-run) or a step event (step mode).
  - On an advance: drive fsm_w=pattern[bit_idx] and fsm_en=1 for exactly one cycle; increment bit_idx.
  - Between advances: fsm_en=0 and fsm_w holds its last value.
  - When the advance that plays bit len-1 is issued, go to SETTLE.
- Hit sampling: z is Moore, so it is valid in the cycle after the detector's enabled edge.
  - The controller samples fsm_z in the cycle two cycles after it issues fsm_en=1, i.e. one cycle after the detector's enabled clock edge.
  - Each sample with fsm_z=1 increments hit_count.
  - In step mode the state is stable between advances, so exactly one sample is taken per advance.
- SETTLE: waits until the sample for the final bit has been taken, then goes to DONE.
- Entering DONE: busy=0, done=1.
- hit_count saturates at 2^CNT_W-1; it never wraps.
- start while busy=1 is ignored.
- step in free-run mode, or outside PLAY, is ignored.
- reset in any state, including mid-PLAY, returns to the reset values on the next edge; any partial count is discarded.
- start and reset in the same cycle: reset wins.

Optional Feature:
- Macro: SEQ_DET_PLAYER_STEP_SYNC_EN.
- Defined:
  - step passes through a 2-flop synchronizer, then a rising-edge detector.
  - A step event is one cycle per low-to-high transition, so a held push gives one advance.
  - Adds 3 cycles of step-to-fsm_en latency.
- Undefined:
  - step is a clean synchronous signal.
  - Each cycle with step=1 in step mode is an advance event (level-sensitive).

Test Plan:
- Free-run, pattern=16'h000F, len=8 (w=1,1,1,1,0,0,0,0) -> 8 fsm_en pulses; done=1; hit_count=2 (after the 4th one and the 4th zero).
- Free-run, pattern=16'hFFFF, len=6 -> hit_count=3; bit_idx=6; busy falls in the cycle done rises.
- Step mode, pattern=16'h0005, len=4 with 4 step events spaced 10 cycles apart -> exactly 4 single-cycle fsm_en pulses, one per step; no fsm_en between steps; hit_count=0.
- len=0 -> CLEAR then DONE; no fsm_en pulse; hit_count=0. len=20 -> clamped, 16 fsm_en pulses.
- reset asserted at bit_idx=3 mid-PLAY -> next cycle: busy=0, hit_count=0, fsm_rst=1. A start during busy=1 -> no restart; bit_idx continues.
- CNT_W=2, pattern=16'hFFFF, len=16 -> 13 z samples high; hit_count saturates at 3.
  - With SEQ_DET_PLAYER_STEP_SYNC_EN, holding step high for 50 cycles -> exactly one advance.

Source files
------------

// File: rtl/seq_det_player.sv
// Test-sequence controller that replays a latched bit pattern into the sequence detector and counts z hits.
// Optional build macro: SEQ_DET_PLAYER_STEP_SYNC_EN (synchronised, edge-detected step input).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | after reset; detector held in reset, waiting for start
// S_CLEAR  | one cycle of detector reset before playing
// S_PLAY   | issuing one enabled bit per advance event
// S_SETTLE | last bit issued; waiting for its z sample
// S_DONE   | run finished; done held until next start
module seq_det_player #(
    parameter int PAT_W = 16,
    parameter int LEN_W = 5,
    parameter int CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             step_mode_i,
    input  logic             step_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             fsm_z_i,
    output logic             fsm_w_o,
    output logic             fsm_en_o,
    output logic             fsm_rst_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] hit_count_o,
    output logic [LEN_W-1:0] bit_idx_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_PLAY,
        S_SETTLE,
        S_DONE
    } state_t;

    localparam logic [LEN_W-1:0] PAT_LEN = LEN_W'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             step_mode_q, step_mode_d;
    logic [LEN_W-1:0] bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;
    logic             fsm_w_q, fsm_w_d;
    logic             fsm_en_q, fsm_en_d;
    logic             fsm_rst_q, fsm_rst_d;
    logic             smp_q;
    logic [PAT_W-1:0] pat_shift;
    logic             step_evt;

`ifdef SEQ_DET_PLAYER_STEP_SYNC_EN
    logic step_s1_q, step_s2_q, step_s3_q, step_pulse_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            step_s1_q    <= 1'b0;
            step_s2_q    <= 1'b0;
            step_s3_q    <= 1'b0;
            step_pulse_q <= 1'b0;
        end else begin
            step_s1_q    <= step_i;
            step_s2_q    <= step_s1_q;
            step_s3_q    <= step_s2_q;
            step_pulse_q <= step_s2_q & ~step_s3_q;
        end
    end

    assign step_evt = step_pulse_q;
`else
    assign step_evt = step_i;
`endif

    assign pat_shift = pattern_q >> bit_idx_q;

    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        len_d       = len_q;
        step_mode_d = step_mode_q;
        bit_idx_d   = bit_idx_q;
        hit_count_d = hit_count_q;
        fsm_w_d     = fsm_w_q;
        fsm_en_d    = 1'b0;
        fsm_rst_d   = fsm_rst_q;

        // z is Moore: it reflects the enabled edge one cycle after fsm_en was high
        if (smp_q && fsm_z_i && (hit_count_q != CNT_MAX)) begin
            hit_count_d = hit_count_q + 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    pattern_d   = pattern_i;
                    len_d       = (len_i > PAT_LEN) ? PAT_LEN : len_i;
                    step_mode_d = step_mode_i;
                    hit_count_d = '0;
                    bit_idx_d   = '0;
                    state_d     = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = (len_q == '0) ? S_DONE : S_PLAY;
            end
            S_PLAY: begin
                if (!step_mode_q || step_evt) begin
                    fsm_en_d  = 1'b1;
                    fsm_w_d   = pat_shift[0];
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == len_q - 1'b1) begin
                        state_d = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (smp_q && !fsm_en_q) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_CLEAR) begin
            fsm_rst_d = 1'b1;
        end else if (state_d == S_PLAY) begin
            fsm_rst_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            pattern_q   <= '0;
            len_q       <= '0;
            step_mode_q <= 1'b0;
            bit_idx_q   <= '0;
            hit_count_q <= '0;
            fsm_w_q     <= 1'b0;
            fsm_en_q    <= 1'b0;
            fsm_rst_q   <= 1'b1;
            smp_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pattern_q   <= pattern_d;
            len_q       <= len_d;
            step_mode_q <= step_mode_d;
            bit_idx_q   <= bit_idx_d;
            hit_count_q <= hit_count_d;
            fsm_w_q     <= fsm_w_d;
            fsm_en_q    <= fsm_en_d;
            fsm_rst_q   <= fsm_rst_d;
            smp_q       <= fsm_en_q;
        end
    end

    assign fsm_w_o     = fsm_w_q;
    assign fsm_en_o    = fsm_en_q;
    assign fsm_rst_o   = fsm_rst_q;
    assign busy_o      = (state_q == S_CLEAR) || (state_q == S_PLAY) || (state_q == S_SETTLE);
    assign done_o      = (state_q == S_DONE);
    assign hit_count_o = hit_count_q;
    assign bit_idx_o   = bit_idx_q;

endmodule
